// File: rtl/anton_neopixel_stream_pkg.sv
// Shared constants, state encodings and helpers for the neopixel stream.
// Timing defaults are in clocks of busClk.
package anton_neopixel_stream_pkg;

  localparam int BUFFER_END_DEFAULT = 255;
  localparam int T0H_DEFAULT        = 8;
  localparam int T1H_DEFAULT        = 16;
  localparam int BIT_DEFAULT        = 25;
  localparam int RESET_DEFAULT      = 1000;
  localparam int REG_W              = 13;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_BIT   = 3'd2,
    ST_LATCH = 3'd3,
    ST_INIT  = 3'd4
  } np_state_t;

  function automatic logic [REG_W-1:0] clamp_last(
    input logic             lim,
    input logic [REG_W-1:0] maxv,
    input logic [REG_W-1:0] end_idx
  );
    if (lim && maxv < end_idx) return maxv;
    return end_idx;
  endfunction

endpackage

// File: rtl/anton_neopixel_stream_bit_timer.sv
// One WS2812 bit period: free-running period counter and high-time compare.
// Runs back-to-back periods for as long as start is held.
module anton_neopixel_bit_timer
  import anton_neopixel_stream_pkg::*;
#(
  parameter int CYCLES_T0H = T0H_DEFAULT,
  parameter int CYCLES_T1H = T1H_DEFAULT,
  parameter int CYCLES_BIT = BIT_DEFAULT
) (
  input  logic busClk,
  input  logic busRst_n,
  input  logic start,
  input  logic bit_value,
  output logic pulse,
  output logic bit_done
);

  localparam int CW = (CYCLES_BIT > 1) ? $clog2(CYCLES_BIT) : 1;

  logic [CW-1:0] cnt;
  logic          at_end;
  logic          hi;

  assign at_end = cnt == CW'(CYCLES_BIT - 1);

  always_ff @(posedge busClk or negedge busRst_n) begin
    if (!busRst_n) begin
      cnt <= '0;
    end else if (!start || at_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign hi       = bit_value ? (cnt < CW'(CYCLES_T1H))
                              : (cnt < CW'(CYCLES_T0H));
  assign pulse    = start && hi;
  assign bit_done = start && at_end;

endmodule

// File: rtl/anton_neopixel_stream.sv
// Serialises pixel buffer bytes onto a WS2812 data wire with latch/init gaps.
// ANTON_NEOPIXEL_STREAM_RGBW_EN: 32bit mode also sends byte 3 of each pixel.
module anton_neopixel_stream
  import anton_neopixel_stream_pkg::*;
#(
  parameter  int BUFFER_END   = BUFFER_END_DEFAULT,
  parameter  int CYCLES_T0H   = T0H_DEFAULT,
  parameter  int CYCLES_T1H   = T1H_DEFAULT,
  parameter  int CYCLES_BIT   = BIT_DEFAULT,
  parameter  int CYCLES_RESET = RESET_DEFAULT,
  localparam int AW           = $clog2(BUFFER_END + 1)
) (
  input  logic             busClk,
  input  logic             busRst_n,
  output logic [AW-1:0]    pixelAddr,
  input  logic [7:0]       pixelData,
  input  logic [REG_W-1:0] reg_max,
  input  logic             reg_ctrl_limit,
  input  logic             reg_ctrl_run,
  input  logic             reg_ctrl_32bit,
  input  logic             initSlow,
  output logic             neoData,
  output logic             state,
  output logic             stream_sync_of,
  output logic             initSlowDone
);

  localparam int GW = (CYCLES_RESET > 1) ? $clog2(CYCLES_RESET) : 1;
  localparam logic [REG_W-1:0] END_IDX = REG_W'(BUFFER_END);
`ifdef ANTON_NEOPIXEL_STREAM_RGBW_EN
  localparam logic RGBW = 1'b1;
`else
  localparam logic RGBW = 1'b0;
`endif
  localparam logic [1:0] END_SLOT = RGBW ? 2'd3 : 2'd2;

  np_state_t st_q, st_d;

  logic             fetch_ph_q;
  logic             final_q;
  logic             init_skip_q;
  logic             m32_q;
  logic [REG_W-1:0] last_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       pf_q;
  logic [1:0]       rd_q;
  logic [GW-1:0]    gap_q;

  logic             bit_done;
  logic             byte_end;
  logic             gap_last;
  logic             addr_end;
  logic             addr_skip;
  logic [REG_W-1:0] addr;
  logic [REG_W-1:0] addr_inc;
  logic [REG_W-1:0] addr_next;

  anton_neopixel_bit_timer #(
    .CYCLES_T0H (CYCLES_T0H),
    .CYCLES_T1H (CYCLES_T1H),
    .CYCLES_BIT (CYCLES_BIT)
  ) u_timer (
    .busClk    (busClk),
    .busRst_n  (busRst_n),
    .start     (st_q == ST_BIT),
    .bit_value (shift_q[7]),
    .pulse     (neoData),
    .bit_done  (bit_done)
  );

  assign addr     = REG_W'(pixelAddr);
  assign byte_end = bit_done && (bit_idx_q == 3'd7);
  assign gap_last = gap_q == GW'(CYCLES_RESET - 1);

  // pixelAddr still names the byte on the wire when this is evaluated
  always_comb begin
    addr_end = addr >= last_q;
    if (m32_q) begin
      addr_end = (addr[1:0] == END_SLOT &&
                  addr[REG_W-1:2] >= last_q[REG_W-1:2]) ||
                 addr >= END_IDX;
    end
  end

  assign addr_skip = m32_q && !RGBW && (addr[1:0] == 2'd2);
  assign addr_inc  = addr + (addr_skip ? REG_W'(2) : REG_W'(1));
  assign addr_next = (addr_inc > END_IDX) ? END_IDX : addr_inc;

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: begin
        if (initSlow && !init_skip_q) st_d = ST_INIT;
        else if (reg_ctrl_run)        st_d = ST_FETCH;
      end
      ST_FETCH: if (fetch_ph_q)          st_d = ST_BIT;
      ST_BIT:   if (byte_end && final_q) st_d = ST_LATCH;
      ST_LATCH: if (gap_last)            st_d = ST_IDLE;
      ST_INIT:  if (gap_last)            st_d = ST_IDLE;
      default:                           st_d = ST_IDLE;
    endcase
    if (initSlow && st_q != ST_IDLE && st_q != ST_INIT) st_d = ST_INIT;
  end

  always_ff @(posedge busClk or negedge busRst_n) begin
    if (!busRst_n) begin
      st_q        <= ST_IDLE;
      fetch_ph_q  <= 1'b0;
      final_q     <= 1'b0;
      init_skip_q <= 1'b0;
      m32_q       <= 1'b0;
      last_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      pf_q        <= '0;
      rd_q        <= '0;
      gap_q       <= '0;
      pixelAddr   <= '0;
    end else begin
      st_q        <= st_d;
      fetch_ph_q  <= (st_q == ST_FETCH) && (st_d == ST_FETCH);
      init_skip_q <= (st_q == ST_INIT) && (st_d == ST_IDLE);
      gap_q       <= ((st_q == ST_LATCH || st_q == ST_INIT) && st_d == st_q)
                     ? gap_q + 1'b1 : '0;
      rd_q        <= {rd_q[0], 1'b0};
      if (rd_q[1]) pf_q <= pixelData;

      if (st_q == ST_IDLE && st_d == ST_FETCH) begin
        pixelAddr <= '0;
        last_q    <= clamp_last(reg_ctrl_limit, reg_max, END_IDX);
        m32_q     <= reg_ctrl_32bit;
        final_q   <= 1'b0;
        bit_idx_q <= '0;
        rd_q      <= '0;
      end

      if (st_q == ST_FETCH && fetch_ph_q) shift_q <= pixelData;

      // address steps as bit 7 begins; data lands in pf_q two clocks later
      if (st_q == ST_BIT && bit_done) begin
        if (bit_idx_q == 3'd6) begin
          if (addr_end) begin
            final_q <= 1'b1;
          end else begin
            pixelAddr <= AW'(addr_next);
            rd_q[0]   <= 1'b1;
          end
        end
        if (bit_idx_q == 3'd7) shift_q <= pf_q;
        else                   shift_q <= {shift_q[6:0], 1'b0};
        bit_idx_q <= bit_idx_q + 1'b1;
      end
    end
  end

  assign state          = (st_q == ST_FETCH) || (st_q == ST_BIT);
  assign stream_sync_of = (st_q == ST_LATCH) && gap_last;
  assign initSlowDone   = (st_q == ST_INIT) && gap_last;

endmodule

// File: tb/tb_anton_neopixel_stream.sv
// Directed bench for anton_neopixel_stream: decodes the wire into bits,
// checks bytes, timing, latch gap, init abort and async reset.
module tb_anton_neopixel_stream;

  localparam int BE = 7;
  localparam int T0 = 2;
  localparam int T1 = 4;
  localparam int TB = 6;
  localparam int TR = 20;
  localparam int NS = 800;

  logic        busClk = 1'b0;
  logic        busRst_n = 1'b0;
  logic [2:0]  pixelAddr;
  logic [7:0]  pixelData;
  logic [12:0] reg_max = '0;
  logic        reg_ctrl_limit = 1'b0;
  logic        reg_ctrl_run = 1'b0;
  logic        reg_ctrl_32bit = 1'b0;
  logic        initSlow = 1'b0;
  logic        neoData;
  logic        state;
  logic        stream_sync_of;
  logic        initSlowDone;

  logic [7:0] mem [0:7];

  always #5 busClk = ~busClk;

  always @(posedge busClk) pixelData <= mem[pixelAddr];

  anton_neopixel_stream #(
    .BUFFER_END   (BE),
    .CYCLES_T0H   (T0),
    .CYCLES_T1H   (T1),
    .CYCLES_BIT   (TB),
    .CYCLES_RESET (TR)
  ) dut (
    .busClk         (busClk),
    .busRst_n       (busRst_n),
    .pixelAddr      (pixelAddr),
    .pixelData      (pixelData),
    .reg_max        (reg_max),
    .reg_ctrl_limit (reg_ctrl_limit),
    .reg_ctrl_run   (reg_ctrl_run),
    .reg_ctrl_32bit (reg_ctrl_32bit),
    .initSlow       (initSlow),
    .neoData        (neoData),
    .state          (state),
    .stream_sync_of (stream_sync_of),
    .initSlowDone   (initSlowDone)
  );

  typedef struct {
    string       nm;
    logic        lim;
    logic [12:0] maxv;
    logic        m32;
    int          n;
    logic [63:0] exp;
  } vec_t;

  vec_t vt [8];

  int total = 0;
  int bad = 0;

  logic neo_s [NS];
  logic st_s  [NS];
  logic sy_s  [NS];
  int   ns;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic setv(input int i, input string nm, input logic lim,
                      input int maxv, input logic m32, input int n,
                      input logic [63:0] exp);
    vt[i].nm   = nm;
    vt[i].lim  = lim;
    vt[i].maxv = 13'(maxv);
    vt[i].m32  = m32;
    vt[i].n    = n;
    vt[i].exp  = exp;
  endtask

  // samples one frame; run drops drop_after clocks after state rises
  task automatic record(input int drop_after, input bit chg);
    int rise;
    int post;
    rise = -1;
    post = -1;
    ns = 0;
    while (ns < NS && !(post >= 0 && ns >= post + 4)) begin
      @(negedge busClk);
      neo_s[ns] = neoData;
      st_s[ns]  = state;
      sy_s[ns]  = stream_sync_of;
      if (state && rise < 0) rise = ns;
      if (rise >= 0 && ns - rise == drop_after) begin
        reg_ctrl_run = 1'b0;
        if (chg) begin
          reg_ctrl_limit = 1'b0;
          reg_max = 13'd7;
          reg_ctrl_32bit = 1'b1;
        end
      end
      if (stream_sync_of && post < 0) post = ns;
      ns++;
    end
    total++;
    if (post < 0) begin
      bad++;
      $display("FAIL timeout: no stream_sync_of within %0d clocks", NS);
    end
  endtask

  task automatic check_frame(input string nm, input int nbytes,
                             input logic [63:0] exp);
    int f, r, nb, shp, stc, syn, s, e, hia, h, b;
    logic [63:0] data;
    f = -1; r = -1; nb = 0; shp = 0; stc = 0; syn = 0; s = -1; hia = 0;
    data = '0;
    for (int i = 0; i < ns; i++) begin
      if (neo_s[i] && f < 0) f = i;
      if (st_s[i] && r < 0) r = i;
      if (st_s[i]) stc++;
      if (sy_s[i]) begin
        syn++;
        if (s < 0) s = i;
      end
    end
    if (f >= 0) begin
      while (nb < 64 && f + TB * (nb + 1) <= ns && neo_s[f + TB * nb]) begin
        b = f + TB * nb;
        h = 0;
        while (h < TB && neo_s[b + h]) h++;
        for (int j = h; j < TB; j++) if (neo_s[b + j]) shp++;
        if (h != T0 && h != T1) shp++;
        data = {data[62:0], (h == T1)};
        nb++;
      end
    end
    e = f + TB * nb;
    for (int i = (e < 0 ? 0 : e); i < ns; i++) if (neo_s[i]) hia++;
    chk({nm, " bits"}, nb, 8 * nbytes);
    chk({nm, " data"}, data, exp);
    chk({nm, " shape"}, shp, 0);
    chk({nm, " fetch_lat"}, f - r, 2);
    chk({nm, " state_clks"}, stc, 2 + 8 * TB * nbytes);
    chk({nm, " sync_cnt"}, syn, 1);
    chk({nm, " latch_len"}, s - e, TR - 1);
    chk({nm, " latch_low"}, hia, 0);
  endtask

  task automatic wait_neo(input string nm);
    int k;
    k = 0;
    while (!neoData && k < 50) begin
      @(negedge busClk);
      k++;
    end
    chk({nm, " first_high"}, neoData, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int ndone, nneo, nst, nsy, dat;
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hF0; mem[3] = 8'h0F;
    mem[4] = 8'h81; mem[5] = 8'h7E; mem[6] = 8'h55; mem[7] = 8'hC3;

    setv(0, "one_byte",  1'b1, 0,    1'b0, 1, 64'hA5);
    setv(1, "full",      1'b0, 0,    1'b0, 8, 64'hA53CF00F817E55C3);
`ifdef ANTON_NEOPIXEL_STREAM_RGBW_EN
    setv(2, "m32_full",  1'b0, 0,    1'b1, 8, 64'hA53CF00F817E55C3);
    setv(5, "m32_max4",  1'b1, 4,    1'b1, 8, 64'hA53CF00F817E55C3);
    setv(6, "m32_max1",  1'b1, 1,    1'b1, 4, 64'hA53CF00F);
`else
    setv(2, "m32_full",  1'b0, 0,    1'b1, 6, 64'hA53CF0817E55);
    setv(5, "m32_max4",  1'b1, 4,    1'b1, 6, 64'hA53CF0817E55);
    setv(6, "m32_max1",  1'b1, 1,    1'b1, 3, 64'hA53CF0);
`endif
    setv(3, "max2",      1'b1, 2,    1'b0, 3, 64'hA53CF0);
    setv(4, "max_clamp", 1'b1, 20,   1'b0, 8, 64'hA53CF00F817E55C3);
    setv(7, "max_big",   1'b1, 4096, 1'b0, 8, 64'hA53CF00F817E55C3);

    repeat (3) @(negedge busClk);
    chk("rst neoData", neoData, 0);
    chk("rst state", state, 0);
    chk("rst sync", stream_sync_of, 0);
    chk("rst done", initSlowDone, 0);
    chk("rst addr", pixelAddr, 0);
    busRst_n = 1'b1;
    repeat (3) @(negedge busClk);
    chk("idle state", state, 0);

    for (int i = 0; i < 8; i++) begin
      @(negedge busClk);
      reg_ctrl_limit = vt[i].lim;
      reg_max        = vt[i].maxv;
      reg_ctrl_32bit = vt[i].m32;
      reg_ctrl_run   = 1'b1;
      record(0, 1'b0);
      check_frame(vt[i].nm, vt[i].n, vt[i].exp);
    end

    // run dropped and config changed after the first byte
    @(negedge busClk);
    reg_ctrl_limit = 1'b1;
    reg_max = 13'd2;
    reg_ctrl_32bit = 1'b0;
    reg_ctrl_run = 1'b1;
    record(2 + 8 * TB, 1'b1);
    check_frame("run_drop", 3, 64'hA53CF0);

    // initSlow at byte 3 bit 5
    @(negedge busClk);
    reg_ctrl_limit = 1'b0;
    reg_ctrl_32bit = 1'b0;
    reg_ctrl_run = 1'b1;
    wait_neo("init");
    repeat (29 * TB) @(negedge busClk);
    chk("init pre state", state, 1);
    initSlow = 1'b1;
    reg_ctrl_run = 1'b0;
    ndone = -1; nneo = 0; nst = 0; nsy = 0;
    for (int i = 1; i <= TR; i++) begin
      @(negedge busClk);
      if (i == 1) chk("init abort neo", neoData, 0);
      if (initSlowDone && ndone < 0) ndone = i;
      nneo += int'(neoData);
      nst  += int'(state);
      nsy  += int'(stream_sync_of);
    end
    chk("init done_at", ndone, TR);
    chk("init neo_low", nneo, 0);
    chk("init state_low", nst, 0);
    chk("init no_sync", nsy, 0);
    @(negedge busClk);
    dat = int'(initSlowDone);
    @(negedge busClk);
    initSlow = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge busClk);
      dat += int'(initSlowDone) + int'(state) + int'(stream_sync_of);
    end
    chk("init ignore_after_done", dat, 0);

    // async reset mid-bit, then restart from byte 0
    @(negedge busClk);
    reg_ctrl_limit = 1'b1;
    reg_max = 13'd1;
    reg_ctrl_run = 1'b1;
    wait_neo("rst_mid");
    repeat (10 * TB) @(negedge busClk);
    chk("rst_mid pre addr", pixelAddr, 1);
    busRst_n = 1'b0;
    #1;
    chk("rst_mid neo", neoData, 0);
    chk("rst_mid state", state, 0);
    chk("rst_mid sync", stream_sync_of, 0);
    chk("rst_mid done", initSlowDone, 0);
    chk("rst_mid addr", pixelAddr, 0);
    repeat (2) @(negedge busClk);
    busRst_n = 1'b1;
    record(0, 1'b0);
    check_frame("after_rst", 2, 64'hA53C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
